// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the MIPS data-memory / MMIO subsystem.
// Also holds the load-result extension helper.
package mips_mem_pkg;

  localparam int          WORD_W = 32;
  localparam logic [15:0] IO_LOW = 16'hFF00;
  localparam logic [15:0] IO_TOP = 16'hFFFC;

  typedef enum logic [1:0] {
    SIZE_WORD = 2'b00,
    SIZE_HALF = 2'b01,
    SIZE_BYTE = 2'b10,
    SIZE_RSVD = 2'b11
  } mem_size_e;

  typedef enum logic [1:0] {
    SRC_NONE = 2'b00,
    SRC_RAM  = 2'b01,
    SRC_IO   = 2'b10
  } rd_src_e;

  function automatic logic [WORD_W-1:0] extend(input logic [WORD_W-1:0] word,
                                               input logic [1:0]        lane,
                                               input mem_size_e         size,
                                               input logic              uns);
    logic [15:0] half_v;
    logic [7:0]  byte_v;
    half_v = lane[1] ? word[31:16] : word[15:0];
    case (lane)
      2'd0:    byte_v = word[7:0];
      2'd1:    byte_v = word[15:8];
      2'd2:    byte_v = word[23:16];
      default: byte_v = word[31:24];
    endcase
    case (size)
      SIZE_WORD: extend = word;
      SIZE_HALF: extend = {{16{half_v[15] & ~uns}}, half_v};
      SIZE_BYTE: extend = {{24{byte_v[7] & ~uns}}, byte_v};
      default:   extend = '0;
    endcase
  endfunction

endpackage

// File: rtl/mips_mem_ram.sv
// Single-port synchronous RAM, 32-bit words with four byte enables.
// Read-first: a same-edge read returns the contents before the write.
module mips_mem_ram #(
  parameter int WORDS     = 256,
  parameter     INIT_FILE = ""
) (
  input  logic                     clk,
  input  logic                     en,
  input  logic                     we,
  input  logic [3:0]               be,
  input  logic [$clog2(WORDS)-1:0] addr,
  input  logic [31:0]              wdata,
  output logic [31:0]              rdata
);

  logic [31:0] mem [WORDS];

  always_ff @(posedge clk) begin
    if (en) rdata <= mem[addr];
    if (we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/mips_memory_mmio.sv
// Data memory for the multi-cycle MIPS datapath: byte-enabled RAM, switch
// input ports, output registers, access-fault detection and load extension.
module mips_memory_mmio
  import mips_mem_pkg::*;
#(
  parameter int RAM_WORDS    = 256,
  parameter int NUM_INPORTS  = 2,
  parameter int NUM_OUTPORTS = 1,
  parameter     INIT_FILE    = ""
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_INPORTS-1:0]    InportEn,
  input  logic [31:0]               Extended_Switch_Data,
  input  logic                      MemWrite,
  input  logic                      MemRead,
  input  logic [1:0]                MemSize,
  input  logic                      MemUnsigned,
  input  logic [31:0]               WrData,
  input  logic [31:0]               addr,
  output logic [31:0]               RdData,
  output logic [32*NUM_OUTPORTS-1:0] Output_Port,
  output logic                      MisalignFault
);

  localparam int AW = $clog2(RAM_WORDS);

  mem_size_e   size;
  logic        in_ram, in_io, bad, ram_en, ram_we;
  logic [3:0]  be;
  logic [31:0] wdata_rep, io_rd, ram_q;
  logic [31:0] in_q  [NUM_INPORTS];
  logic [31:0] out_q [NUM_OUTPORTS];

  rd_src_e     src_p0;
  logic [31:0] io_word_p0;
  logic [1:0]  lane_p0;
  mem_size_e   size_p0;
  logic        uns_p0;
  logic        fault_p0;

  assign size = mem_size_e'(MemSize);

  always_comb begin
    in_ram = addr < 32'(4 * RAM_WORDS);
    in_io  = (addr[31:16] == 16'h0) && (addr[15:0] >= IO_LOW);
    case (size)
      SIZE_WORD: bad = addr[1:0] != 2'b00;
      SIZE_HALF: bad = addr[0] | in_io;
      SIZE_BYTE: bad = in_io;
      default:   bad = 1'b1;
    endcase
    ram_en = MemRead  & in_ram & ~bad & ~rst;
    ram_we = MemWrite & in_ram & ~bad & ~rst;
  end

  // Sub-word stores replicate the low data bits into every lane; the enables pick one.
  always_comb begin
    case (size)
      SIZE_HALF: begin
        be        = addr[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{WrData[15:0]}};
      end
      SIZE_BYTE: begin
        be        = 4'b0001 << addr[1:0];
        wdata_rep = {4{WrData[7:0]}};
      end
      default: begin
        be        = 4'b1111;
        wdata_rep = WrData;
      end
    endcase
  end

  always_comb begin
    io_rd = '0;
    for (int k = 0; k < NUM_INPORTS; k++) begin
      if (addr[15:0] == IO_TOP - 16'(4 * (NUM_INPORTS - 1 - k))) io_rd = in_q[k];
    end
  end

  mips_mem_ram #(.WORDS(RAM_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .be    (be),
    .addr  (addr[AW+1:2]),
    .wdata (wdata_rep),
    .rdata (ram_q)
  );

  // Inports deliberately ignore rst so captured switch values survive a CPU reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_INPORTS; k++) begin
      if (InportEn[k]) in_q[k] <= Extended_Switch_Data;
    end
  end

  always_ff @(posedge clk) begin
    for (int j = 0; j < NUM_OUTPORTS; j++) begin
      if (rst) begin
        out_q[j] <= '0;
      end else if (MemWrite && in_io && !bad && addr[15:0] == IO_TOP - 16'(4 * j)) begin
        out_q[j] <= WrData;
      end
    end
  end

  // Stage p0: load select captured on the MemRead edge
  always_ff @(posedge clk) begin
    if (rst) begin
      src_p0   <= SRC_NONE;
      fault_p0 <= 1'b0;
    end else begin
      fault_p0 <= (MemRead | MemWrite) & (in_ram | in_io) & bad;
      if (MemRead) begin
        if (bad || !(in_ram || in_io)) src_p0 <= SRC_NONE;
        else if (in_ram)               src_p0 <= SRC_RAM;
        else                           src_p0 <= SRC_IO;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (MemRead) begin
      io_word_p0 <= io_rd;
      lane_p0    <= addr[1:0];
      size_p0    <= size;
      uns_p0     <= MemUnsigned;
    end
  end

  always_comb begin
    case (src_p0)
      SRC_RAM: RdData = extend(ram_q, lane_p0, size_p0, uns_p0);
      SRC_IO:  RdData = io_word_p0;
      default: RdData = '0;
    endcase
    for (int j = 0; j < NUM_OUTPORTS; j++) Output_Port[32*j +: 32] = out_q[j];
  end

  assign MisalignFault = fault_p0;

endmodule

// File: tb/tb_mips_memory_mmio.sv
// Self-checking bench for mips_memory_mmio: directed scenarios plus a
// randomized run against a byte-array reference model.
module tb_mips_memory_mmio;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  InportEn;
  logic [31:0] Extended_Switch_Data;
  logic        MemWrite, MemRead, MemUnsigned;
  logic [1:0]  MemSize;
  logic [31:0] WrData, addr, RdData;
  logic [31:0] Output_Port;
  logic        MisalignFault;

  int n_checks = 0;
  int n_fail   = 0;

  logic [7:0]  m_mem [1024];
  logic [31:0] m_in  [2];
  logic [31:0] m_out;
  logic [31:0] m_rd;
  logic        m_fault;

  always #5 clk = ~clk;

  mips_memory_mmio #(
    .RAM_WORDS(256), .NUM_INPORTS(2), .NUM_OUTPORTS(1), .INIT_FILE("")
  ) dut (
    .clk(clk), .rst(rst), .InportEn(InportEn),
    .Extended_Switch_Data(Extended_Switch_Data),
    .MemWrite(MemWrite), .MemRead(MemRead), .MemSize(MemSize),
    .MemUnsigned(MemUnsigned), .WrData(WrData), .addr(addr),
    .RdData(RdData), .Output_Port(Output_Port), .MisalignFault(MisalignFault)
  );

  // Reference model: memory as a plain byte array, ports as variables.
  function automatic void model_step(input logic rs, r, w, input logic [1:0] sz,
                                     input logic u, input logic [31:0] a, wd,
                                     input logic [1:0] en, input logic [31:0] sw);
    bit ram, io, bad;
    logic [31:0] wv, v;
    int base, n;
    ram = a < 1024;
    io  = (a[31:16] == 16'h0) && (a[15:0] >= 16'hFF00);
    bad = (sz == 3) || (sz == 0 && a[1:0] != 0) || (sz == 1 && a[0]) || (io && sz != 0);
    if (rs) begin
      m_rd = 0; m_out = 0; m_fault = 0;
    end else begin
      m_fault = (r || w) && (ram || io) && bad;
      if (r) begin
        if (!(ram || io) || bad) m_rd = 0;
        else if (ram) begin
          base = int'(a & 32'h3FC);
          wv = {m_mem[base+3], m_mem[base+2], m_mem[base+1], m_mem[base]};
          if (sz == 0) v = wv;
          else if (sz == 1) begin
            v = (wv >> (a[1] * 16)) & 32'hFFFF;
            if (!u && v[15]) v = v | 32'hFFFF0000;
          end else begin
            v = (wv >> (8 * a[1:0])) & 32'hFF;
            if (!u && v[7]) v = v | 32'hFFFFFF00;
          end
          m_rd = v;
        end else if (a[15:0] == 16'hFFF8) m_rd = m_in[0];
        else if (a[15:0] == 16'hFFFC) m_rd = m_in[1];
        else m_rd = 0;
      end
      if (w && !bad) begin
        if (ram) begin
          n = (sz == 0) ? 4 : (sz == 1) ? 2 : 1;
          for (int i = 0; i < n; i++) m_mem[int'(a & 32'h3FF) + i] = wd[8*i +: 8];
        end else if (io && a[15:0] == 16'hFFFC) m_out = wd;
      end
    end
    for (int k = 0; k < 2; k++) if (en[k]) m_in[k] = sw;
  endfunction

  task automatic access(input logic rs, r, w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, wd, input logic [1:0] en,
                        input logic [31:0] sw);
    @(negedge clk);
    rst = rs; MemRead = r; MemWrite = w; MemSize = sz; MemUnsigned = u;
    addr = a; WrData = wd; InportEn = en; Extended_Switch_Data = sw;
    model_step(rs, r, w, sz, u, a, wd, en, sw);
    @(posedge clk);
    #1;
    rst = 0; MemRead = 0; MemWrite = 0; InportEn = 0;
  endtask

  task automatic rd(input logic [1:0] sz, input logic u, input logic [31:0] a);
    access(0, 1, 0, sz, u, a, 32'h0, 2'b00, 32'h0);
  endtask

  task automatic wr(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] wd);
    access(0, 0, 1, sz, 0, a, wd, 2'b00, 32'h0);
  endtask

  task automatic idle();
    access(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 2'b00, 32'h0);
  endtask

  task automatic test_reset();
    access(1, 1, 1, 2'b00, 0, 32'h0, 32'h12345678, 2'b00, 32'h0);
    n_checks++; if (RdData !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h exp 0", RdData); end
    n_checks++; if (Output_Port !== 32'h0) begin n_fail++; $display("FAIL reset_out got %h exp 0", Output_Port); end
    n_checks++; if (MisalignFault !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b exp 0", MisalignFault); end
  endtask

  task automatic fill_ram();
    for (int i = 0; i < 256; i++) wr(2'b00, 32'(4 * i), $urandom);
  endtask

  task automatic test_word();
    wr(2'b00, 32'h0, 32'h0A0B0C0D);
    rd(2'b00, 0, 32'h0);
    n_checks++; if (RdData !== 32'h0A0B0C0D) begin n_fail++; $display("FAIL lw0 got %h exp 0a0b0c0d", RdData); end
    n_checks++; if (MisalignFault !== 1'b0) begin n_fail++; $display("FAIL lw0_fault got %b exp 0", MisalignFault); end
    idle();
    n_checks++; if (RdData !== 32'h0A0B0C0D) begin n_fail++; $display("FAIL rd_hold got %h exp 0a0b0c0d", RdData); end
  endtask

  task automatic test_subword();
    rd(2'b10, 0, 32'h3);
    n_checks++; if (RdData !== 32'h0000000A) begin n_fail++; $display("FAIL lb3 got %h exp 0000000a", RdData); end
    wr(2'b10, 32'h1, 32'h000000FF);
    rd(2'b10, 0, 32'h1);
    n_checks++; if (RdData !== 32'hFFFFFFFF) begin n_fail++; $display("FAIL lb1 got %h exp ffffffff", RdData); end
    rd(2'b10, 1, 32'h1);
    n_checks++; if (RdData !== 32'h000000FF) begin n_fail++; $display("FAIL lbu1 got %h exp 000000ff", RdData); end
    rd(2'b00, 0, 32'h0);
    n_checks++; if (RdData !== 32'h0A0BFF0D) begin n_fail++; $display("FAIL lw_after_sb got %h exp 0a0bff0d", RdData); end
  endtask

  task automatic test_misalign();
    wr(2'b00, 32'h0, 32'h80010000);
    rd(2'b01, 0, 32'h2);
    n_checks++; if (RdData !== 32'hFFFF8001) begin n_fail++; $display("FAIL lh2 got %h exp ffff8001", RdData); end
    rd(2'b01, 1, 32'h2);
    n_checks++; if (RdData !== 32'h00008001) begin n_fail++; $display("FAIL lhu2 got %h exp 00008001", RdData); end
    rd(2'b00, 0, 32'h2);
    n_checks++; if (MisalignFault !== 1'b1) begin n_fail++; $display("FAIL lw2_fault got %b exp 1", MisalignFault); end
    n_checks++; if (RdData !== 32'h0) begin n_fail++; $display("FAIL lw2_rd got %h exp 0", RdData); end
    idle();
    n_checks++; if (MisalignFault !== 1'b0) begin n_fail++; $display("FAIL fault_pulse got %b exp 0", MisalignFault); end
    wr(2'b00, 32'h2, 32'hDEADBEEF);
    n_checks++; if (MisalignFault !== 1'b1) begin n_fail++; $display("FAIL sw2_fault got %b exp 1", MisalignFault); end
    rd(2'b11, 0, 32'h0);
    n_checks++; if (MisalignFault !== 1'b1 || RdData !== 32'h0) begin
      n_fail++; $display("FAIL rsvd_size got fault=%b rd=%h exp fault=1 rd=0", MisalignFault, RdData); end
    rd(2'b00, 0, 32'h0);
    n_checks++; if (RdData !== 32'h80010000) begin n_fail++; $display("FAIL ram_unchanged got %h exp 80010000", RdData); end
  endtask

  task automatic test_inports();
    access(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 2'b01, 32'h00010000);
    access(0, 0, 0, 2'b00, 0, 32'h0, 32'h0, 2'b10, 32'h00000001);
    rd(2'b00, 0, 32'hFFF8);
    n_checks++; if (RdData !== 32'h00010000) begin n_fail++; $display("FAIL in0 got %h exp 00010000", RdData); end
    rd(2'b00, 0, 32'hFFFC);
    n_checks++; if (RdData !== 32'h00000001) begin n_fail++; $display("FAIL in1 got %h exp 00000001", RdData); end
    access(0, 1, 0, 2'b00, 0, 32'hFFF8, 32'h0, 2'b01, 32'h00000055);
    n_checks++; if (RdData !== 32'h00010000) begin n_fail++; $display("FAIL in0_same_edge got %h exp 00010000", RdData); end
    rd(2'b00, 0, 32'hFFF8);
    n_checks++; if (RdData !== 32'h00000055) begin n_fail++; $display("FAIL in0_new got %h exp 00000055", RdData); end
  endtask

  task automatic test_outports();
    wr(2'b00, 32'hFFFC, 32'h00001111);
    n_checks++; if (Output_Port !== 32'h00001111) begin n_fail++; $display("FAIL out0 got %h exp 00001111", Output_Port); end
    wr(2'b10, 32'hFFFC, 32'h00000022);
    n_checks++; if (MisalignFault !== 1'b1 || Output_Port !== 32'h00001111) begin
      n_fail++; $display("FAIL sb_io got fault=%b out=%h exp fault=1 out=00001111", MisalignFault, Output_Port); end
    rd(2'b00, 0, 32'h00002000);
    n_checks++; if (MisalignFault !== 1'b0 || RdData !== 32'h0) begin
      n_fail++; $display("FAIL unmapped_rd got fault=%b rd=%h exp fault=0 rd=0", MisalignFault, RdData); end
    wr(2'b10, 32'h00002001, 32'h33);
    n_checks++; if (MisalignFault !== 1'b0) begin n_fail++; $display("FAIL unmapped_wr got %b exp 0", MisalignFault); end
  endtask

  task automatic test_reset_persist();
    rd(2'b00, 0, 32'h0);
    access(1, 1, 1, 2'b00, 0, 32'h8, 32'hCAFEBABE, 2'b00, 32'h0);
    n_checks++; if (RdData !== 32'h0 || Output_Port !== 32'h0) begin
      n_fail++; $display("FAIL mid_reset got rd=%h out=%h exp 0 0", RdData, Output_Port); end
    rd(2'b00, 0, 32'hFFF8);
    n_checks++; if (RdData !== 32'h00000055) begin n_fail++; $display("FAIL in0_persist got %h exp 00000055", RdData); end
    rd(2'b00, 0, 32'hFFFC);
    n_checks++; if (RdData !== 32'h00000001) begin n_fail++; $display("FAIL in1_persist got %h exp 00000001", RdData); end
    rd(2'b00, 0, 32'h8);
    n_checks++; if (RdData !== m_rd) begin n_fail++; $display("FAIL reset_drops_wr got %h exp %h", RdData, m_rd); end
  endtask

  task automatic test_read_first();
    wr(2'b00, 32'h4, 32'hF0F0F0F0);
    access(0, 1, 1, 2'b00, 0, 32'h4, 32'h12345678, 2'b00, 32'h0);
    n_checks++; if (RdData !== 32'hF0F0F0F0) begin n_fail++; $display("FAIL rw_same got %h exp f0f0f0f0", RdData); end
    rd(2'b00, 0, 32'h4);
    n_checks++; if (RdData !== 32'h12345678) begin n_fail++; $display("FAIL rw_after got %h exp 12345678", RdData); end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [1:0]  sz;
    int          cls;
    for (int it = 0; it < 400; it++) begin
      cls = $urandom_range(0, 9);
      if (cls < 6) begin
        a = $urandom_range(0, 1023);
        if ($urandom_range(0, 1) == 0) a = a & 32'hFFFFFFFC;
      end else if (cls < 8) begin
        a = 32'hFF00 + 32'($urandom_range(0, 63) * 4);
        if ($urandom_range(0, 3) == 0) a = a | 32'($urandom_range(1, 3));
      end else if (cls == 8) a = $urandom_range(1024, 32'hFEFF);
      else a = $urandom | 32'h00010000;
      sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      access(($urandom_range(0, 49) == 0), $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
             sz, $urandom_range(0, 1) == 1, a, $urandom, 2'($urandom_range(0, 3)), $urandom);
      n_checks++; if (MisalignFault !== m_fault) begin
        n_fail++; $display("FAIL rnd_fault it=%0d a=%h got %b exp %b", it, a, MisalignFault, m_fault); end
      n_checks++; if (RdData !== m_rd) begin
        n_fail++; $display("FAIL rnd_rd it=%0d a=%h got %h exp %h", it, a, RdData, m_rd); end
      n_checks++; if (Output_Port !== m_out) begin
        n_fail++; $display("FAIL rnd_out it=%0d a=%h got %h exp %h", it, a, Output_Port, m_out); end
    end
  endtask

  initial begin
    rst = 0; MemRead = 0; MemWrite = 0; MemSize = 0; MemUnsigned = 0;
    addr = 0; WrData = 0; InportEn = 0; Extended_Switch_Data = 0;
    m_in[0] = 'x; m_in[1] = 'x; m_out = 'x; m_rd = 'x; m_fault = 'x;
    test_reset();
    fill_ram();
    test_word();
    test_subword();
    test_misalign();
    test_inports();
    test_outports();
    test_reset_persist();
    test_read_first();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
